sram_access_arbiter: RTL and testbench

//   Shares the single asynchronous SRAM between two requesters: port 0 (CPU

---
 rtl/sram_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between the CPU (port 0)
// and the debug/program loader (port 1), with parameterised OE/WE wait states.
module sram_access_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              busy
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic               last_grant_q;
  logic               gnt_q;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               mem_ce_q;
  logic               mem_oe_q;
  logic               mem_we_q;
  logic               p0_done_q;
  logic               p1_done_q;
  logic [DATA_W-1:0]  p0_rdata_q;
  logic [DATA_W-1:0]  p1_rdata_q;
  logic               busy_q;
  logic               gnt_d;

  // On contention the port that was not served last wins
  always_comb begin
    gnt_d = 1'b0;
    if (p0_req && p1_req) begin
      gnt_d = ~last_grant_q;
    end else if (p1_req) begin
      gnt_d = 1'b1;
    end else begin
      gnt_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= {DATA_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      mem_ce_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      p0_done_q    <= 1'b0;
      p1_done_q    <= 1'b0;
      p0_rdata_q   <= {DATA_W{1'b0}};
      p1_rdata_q   <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            last_grant_q <= gnt_d;
            gnt_q        <= gnt_d;
            we_q         <= gnt_d ? p1_we    : p0_we;
            wdata_q      <= gnt_d ? p1_wdata : p0_wdata;
            mem_addr_q   <= gnt_d ? p1_addr  : p0_addr;
            mem_ce_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q       <= we_q ? WR_LOAD : RD_LOAD;
          mem_oe_q    <= ~we_q;
          mem_we_q    <= we_q;
          mem_wdata_q <= we_q ? wdata_q : {DATA_W{1'b0}};
          state_q     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            // SRAM data is sampled while OE is still asserted
            if (!we_q) begin
              if (gnt_q) begin
                p1_rdata_q <= mem_rdata;
              end else begin
                p0_rdata_q <= mem_rdata;
              end
            end
            p0_done_q   <= ~gnt_q;
            p1_done_q   <= gnt_q;
            mem_ce_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          mem_ce_q <= 1'b0;
          mem_oe_q <= 1'b0;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ce    = mem_ce_q;
  assign Mem_OE    = mem_oe_q;
  assign Mem_WE    = mem_we_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed scenarios then random traffic, compared
// every cycle against a transaction-timeline model of the arbiter.
module tb_sram_access_arbiter;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int RD_WAIT = 3;
  localparam int WR_WAIT = 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr, mem_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              p0_done, p1_done, mem_ce, Mem_OE, Mem_WE, busy;

  always #5 Clk = ~Clk;

  sram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce(mem_ce), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .busy(busy)
  );

  // SRAM environment (aliased to 1K words) and the model's own copy
  logic [DATA_W-1:0] sram    [0:1023];
  logic [DATA_W-1:0] ref_mem [0:1023];
  assign mem_rdata = Mem_OE ? sram[mem_addr[9:0]] : 16'h0000;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int d0cnt   = 0;
  int d1cnt   = 0;

  // Model: one transaction at a time, described by its start cycle s (the idle
  // cycle in which it was granted); SETUP at s+1, access s+2..s+1+N, done s+2+N.
  bit                m_active = 1'b0;
  int                m_s      = 0;
  bit                m_port   = 1'b0;
  bit                m_we     = 1'b0;
  bit                m_last   = 1'b1;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [DATA_W-1:0] m_wdata  = '0;
  logic [DATA_W-1:0] ref_rd0  = '0;
  logic [DATA_W-1:0] ref_rd1  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int n, k;
    logic e_ce, e_oe, e_we, e_busy, e_d0, e_d1;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    e_ce = 1'b0; e_oe = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    e_addr = '0; e_wd = '0;
    n = m_we ? WR_WAIT : RD_WAIT;
    k = cyc - m_s;
    if (m_active) begin
      if (k >= 1 && k <= n + 2) e_busy = 1'b1;
      if (k >= 1 && k <= n + 1) begin
        e_ce   = 1'b1;
        e_addr = m_addr;
      end
      if (k >= 2 && k <= n + 1) begin
        e_oe = !m_we;
        e_we = m_we;
        e_wd = m_we ? m_wdata : 16'h0000;
      end
      if (k == n + 2) begin
        e_d0 = !m_port;
        e_d1 = m_port;
      end
    end
    chk("mem_ce",    32'(mem_ce),    32'(e_ce));
    chk("Mem_OE",    32'(Mem_OE),    32'(e_oe));
    chk("Mem_WE",    32'(Mem_WE),    32'(e_we));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("p0_done",   32'(p0_done),   32'(e_d0));
    chk("p1_done",   32'(p1_done),   32'(e_d1));
    chk("p0_rdata",  32'(p0_rdata),  32'(ref_rd0));
    chk("p1_rdata",  32'(p1_rdata),  32'(ref_rd1));
    if (p0_done === 1'b1) d0cnt++;
    if (p1_done === 1'b1) d1cnt++;
  endtask

  // Apply current inputs for one cycle, advance the model across the edge, check.
  task automatic step();
    int  n, k;
    bit  idle;
    if (Mem_WE === 1'b1) sram[mem_addr[9:0]] = mem_wdata;
    n = m_we ? WR_WAIT : RD_WAIT;
    k = cyc - m_s;
    if (m_active && m_we && k >= 2 && k <= n + 1) ref_mem[m_addr[9:0]] = m_wdata;
    if (m_active && !m_we && k == n + 1) begin
      if (m_port) ref_rd1 = ref_mem[m_addr[9:0]];
      else        ref_rd0 = ref_mem[m_addr[9:0]];
    end
    idle = !m_active || (k >= n + 3);
    if (Reset) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      ref_rd0  = '0;
      ref_rd1  = '0;
    end else if (idle) begin
      if (p0_req || p1_req) begin
        m_port   = (p0_req && p1_req) ? !m_last : p1_req;
        m_last   = m_port;
        m_we     = m_port ? p1_we    : p0_we;
        m_addr   = m_port ? p1_addr  : p0_addr;
        m_wdata  = m_port ? p1_wdata : p0_wdata;
        m_s      = cyc;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end
    @(posedge Clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic preload(input int a, input logic [DATA_W-1:0] v);
    sram[a]    = v;
    ref_mem[a] = v;
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = 16'($urandom);
      preload(i, v);
    end
    Reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    step();
    step();
    Reset = 1'b0;

    // 1: p0 read, OE c2..c4, done c5
    preload(12'h012, 16'hBEEF);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h00012;
    repeat (6) step();
    p0_req = 1'b0;
    step();
    chk("t1_p0_rdata", 32'(p0_rdata), 32'h0000BEEF);

    // 2: p1 write, WE c2..c3, done c4
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h00034; p1_wdata = 16'h1234;
    repeat (5) step();
    p1_req = 1'b0;
    step();
    chk("t2_sram", 32'(sram[12'h034]), 32'h00001234);

    // 3: both reads held from reset, alternating grants
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    d0cnt = 0; d1cnt = 0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h00012;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 20'h00034;
    repeat (24) step();
    chk("t3_p0_dones", 32'(d0cnt), 32'd2);
    chk("t3_p1_dones", 32'(d1cnt), 32'd2);
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) step();

    // 4: reset on first WE cycle aborts the write without a done
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h00040; p1_wdata = 16'h4444;
    repeat (2) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0; p1_req = 1'b0;
    repeat (4) step();

    // 5: p0 drops req during SETUP, read still completes
    preload(12'h055, 16'hA5A5);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h00055;
    step();
    p0_req = 1'b0; p0_addr = 20'h00012;
    repeat (6) step();
    chk("t5_p0_rdata", 32'(p0_rdata), 32'h0000A5A5);

    // 6: p0 write leaves p0_rdata alone, then read back the written word
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 20'h00077; p0_wdata = 16'h7777;
    repeat (5) step();
    p0_req = 1'b0;
    step();
    chk("t6_rdata_kept", 32'(p0_rdata), 32'h0000A5A5);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h00077;
    repeat (6) step();
    p0_req = 1'b0;
    step();
    chk("t6_readback", 32'(p0_rdata), 32'h00007777);

    // Random traffic with inputs changing every cycle and occasional resets
    repeat (1500) begin
      Reset    = ($urandom_range(0, 99) == 0);
      p0_req   = ($urandom_range(0, 2) != 0);
      p1_req   = ($urandom_range(0, 2) != 0);
      p0_we    = $urandom_range(0, 1) == 1;
      p1_we    = $urandom_range(0, 1) == 1;
      p0_addr  = 20'($urandom);
      p1_addr  = 20'($urandom);
      p0_wdata = 16'($urandom);
      p1_wdata = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
